// File: rtl/data_step_sequencer.sv
// Command sequencer for the three-digit BCD dekatron data counter (000-255).
// It turns INC/DEC/LOAD/CLEAR commands into timed Step pulses and reports zero, wrap and error status.
module data_step_sequencer #(
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 3,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   CmdValid,
    output logic                   CmdReady,
    input  logic [1:0]             CmdOp,
    input  logic [COUNT_WIDTH-1:0] CmdCount,
    input  logic [11:0]            CmdData,
    output logic                   DoneValid,
    output logic                   DoneZero,
    output logic                   DoneWrap,
    output logic                   DoneError,
    output logic                   Step,
    output logic                   Reverse,
    output logic                   Set,
    output logic [11:0]            DataIn,
    input  logic [11:0]            DataOut
);

    localparam int TMAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] PULSE_LOAD  = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

    localparam logic [1:0] OP_INC   = 2'b00;
    localparam logic [1:0] OP_DEC   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, GAP, DONE} state_t;

    state_t                 state, next;
    logic [1:0]             op_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [11:0]            data_q;
    logic [COUNT_WIDTH-1:0] remaining;
    logic [TW-1:0]          timer;
    logic                   wrap_q;
    logic                   error_q;

    logic                   accept;
    logic                   busy;
    logic                   load_ok;
    logic                   load_bad;
    logic [COUNT_WIDTH-1:0] remaining_init;
    logic                   wrap_hit;

    // Valid BCD value no larger than 255.
    always_comb begin
        load_ok = (data_q[7:4] <= 4'd9) && (data_q[3:0] <= 4'd9) &&
                  ((data_q[11:8] < 4'd2) ||
                   ((data_q[11:8] == 4'd2) &&
                    ((data_q[7:4] < 4'd5) || ((data_q[7:4] == 4'd5) && (data_q[3:0] <= 4'd5)))));
        load_bad       = (op_q == OP_LOAD) && !load_ok;
        remaining_init = op_q[1] ? COUNT_WIDTH'(1) : count_q;
        wrap_hit       = ((op_q == OP_INC) && (DataOut == 12'h255)) ||
                         ((op_q == OP_DEC) && (DataOut == 12'h000));
    end

    always_comb begin
        next      = state;
        CmdReady  = 1'b0;
        busy      = 1'b0;
        Step      = 1'b0;
        DoneValid = 1'b0;
        case (state)
            IDLE: begin
                CmdReady = !Rst;
                if (CmdValid && !Rst) next = SETUP;
            end
            SETUP: begin
                busy = 1'b1;
                if (load_bad || (remaining_init == '0)) next = DONE;
                else                                    next = PULSE;
            end
            PULSE: begin
                busy = 1'b1;
                Step = 1'b1;
                if (timer == '0) next = GAP;
            end
            GAP: begin
                busy = 1'b1;
                if (timer == '0) next = (remaining != '0) ? PULSE : DONE;
            end
            DONE: begin
                DoneValid = 1'b1;
                next      = IDLE;
            end
            default: next = IDLE;
        endcase
        accept    = CmdValid && CmdReady;
        Reverse   = busy && (op_q == OP_DEC);
        Set       = busy && op_q[1];
        DataIn    = (busy && (op_q == OP_LOAD)) ? data_q : '0;
        DoneZero  = DoneValid && (DataOut == 12'h000);
        DoneWrap  = DoneValid && wrap_q;
        DoneError = DoneValid && error_q;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            op_q      <= '0;
            count_q   <= '0;
            data_q    <= '0;
            remaining <= '0;
            timer     <= '0;
            wrap_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state <= next;
            if (accept) begin
                op_q    <= CmdOp;
                count_q <= CmdCount;
                data_q  <= CmdData;
                wrap_q  <= 1'b0;
                error_q <= 1'b0;
            end
            if (state == SETUP) begin
                remaining <= remaining_init;
                if (load_bad) error_q <= 1'b1;
            end
            // The counter value is sampled on every PULSE entry, before that step takes effect.
            if ((next == PULSE) && (state != PULSE)) begin
                timer <= PULSE_LOAD;
                if (wrap_hit) wrap_q <= 1'b1;
            end else if ((state == PULSE) && (next == GAP)) begin
                timer     <= SETTLE_LOAD;
                remaining <= remaining - 1'b1;
            end else if (timer != '0) begin
                timer <= timer - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_step_sequencer.sv
// Self-checking bench for data_step_sequencer: a behavioural dekatron counter plus an
// arithmetic reference model of each command's outcome, with directed and random commands.
module tb_data_step_sequencer;

    localparam int P  = 2;
    localparam int S  = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [CW-1:0] cmd_count = '0;
    logic [11:0]   cmd_data = '0;
    logic          done_valid, done_zero, done_wrap, done_error;
    logic          step, reverse, set_o;
    logic [11:0]   data_in, data_out;

    int n_checks = 0;
    int n_errors = 0;
    int v = 0;
    int ctr = 0;
    logic step_d = 1'b0;

    always #5 clk = ~clk;

    data_step_sequencer #(
        .PULSE_CYCLES (P),
        .SETTLE_CYCLES(S),
        .COUNT_WIDTH  (CW)
    ) dut (
        .Clk      (clk),
        .Rst      (rst),
        .CmdValid (cmd_valid),
        .CmdReady (cmd_ready),
        .CmdOp    (cmd_op),
        .CmdCount (cmd_count),
        .CmdData  (cmd_data),
        .DoneValid(done_valid),
        .DoneZero (done_zero),
        .DoneWrap (done_wrap),
        .DoneError(done_error),
        .Step     (step),
        .Reverse  (reverse),
        .Set      (set_o),
        .DataIn   (data_in),
        .DataOut  (data_out)
    );

    function automatic logic [11:0] to_bcd(input int x);
        return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    function automatic int bcd_value(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit bcd_ok(input logic [11:0] b);
        return (b[11:8] <= 9) && (b[7:4] <= 9) && (b[3:0] <= 9) && (bcd_value(b) <= 255);
    endfunction

    // Dekatron counter model: acts on each rising Step.
    assign data_out = to_bcd(ctr);
    always @(posedge clk) begin
        step_d <= step;
        if (step && !step_d) begin
            if (set_o)        ctr <= bcd_value(data_in) % 256;
            else if (reverse) ctr <= (ctr + 255) % 256;
            else              ctr <= (ctr + 1) % 256;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input int cnt, input logic [11:0] data,
                           input bit hold_valid);
        int n, newv, k, rises, ctl_bad;
        bit err, wrap, seen, prev;
        logic [11:0] dval;
        n = 0; err = 0; wrap = 0; newv = v;
        case (op)
            2'd0: begin n = cnt; wrap = (v + n) > 255; newv = (v + n) % 256; end
            2'd1: begin n = cnt; wrap = n > v; newv = (v - n + 256) % 256; end
            2'd2: if (bcd_ok(data)) begin n = 1; newv = bcd_value(data); end
                  else err = 1;
            default: begin n = 1; newv = 0; end
        endcase
        dval = (op == 2'd2) ? data : 12'h000;

        @(negedge clk);
        k = 0;
        while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
        check("ready_before", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt[CW-1:0]; cmd_data = data;
        @(negedge clk);
        cmd_op = 2'($urandom); cmd_count = CW'($urandom); cmd_data = 12'($urandom);
        if (!hold_valid) cmd_valid = 1'b0;

        k = 1; rises = 0; ctl_bad = 0; seen = 0; prev = 0;
        while (k < 400) begin
            if (done_valid) begin
                seen = 1;
                check("done_latency", k, 2 + n * (P + S));
                check("done_zero", done_zero, newv == 0);
                check("done_wrap", done_wrap, wrap);
                check("done_error", done_error, err);
                check("done_ctl_clear", {step, reverse, set_o, data_in}, 0);
                break;
            end
            if (step && !prev) begin
                rises++;
                if (rises == 1) check("first_step_cycle", k, 2);
            end
            if (reverse !== (op == 2'd1) || set_o !== op[1] || data_in !== dval || cmd_ready !== 1'b0)
                ctl_bad++;
            prev = step;
            @(negedge clk);
            k++;
        end
        if (!seen) check("done_timeout", 0, 1);
        check("step_count", rises, n);
        check("ctl_stable", ctl_bad, 0);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("ready_after", cmd_ready, 1);
        check("data_out", data_out, to_bcd(newv));
        v = newv;
    endtask

    initial begin
        int rises, dones;
        bit prev;
        logic [1:0] op;
        logic [11:0] d;

        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 0);
        check("rst_outputs", {step, reverse, set_o, data_in, done_valid, done_zero, done_wrap, done_error}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_post_rst", cmd_ready, 1);

        run_cmd(2'd0, 3, 12'h000, 0);
        run_cmd(2'd2, 0, 12'h254, 0);
        run_cmd(2'd0, 2, 12'h000, 0);
        run_cmd(2'd1, 1, 12'h000, 0);
        run_cmd(2'd2, 0, 12'h2A0, 0);
        run_cmd(2'd2, 0, 12'h300, 0);
        run_cmd(2'd0, 0, 12'h000, 0);
        run_cmd(2'd0, 5, 12'h000, 1);

        // Reset in the middle of the second pulse of INC 5.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_count = CW'(5);
        @(negedge clk);
        cmd_valid = 1'b0;
        rises = 0; prev = 0;
        for (int k = 0; k < 100; k++) begin
            if (step && !prev) rises++;
            if (rises == 2) break;
            prev = step;
            @(negedge clk);
        end
        check("rst_reach_pulse2", rises, 2);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_step", step, 0);
        check("rst_mid_ready", cmd_ready, 0);
        check("rst_mid_ctl", {reverse, set_o, done_valid}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ready_after", cmd_ready, 1);
        dones = 0;
        repeat (20) begin
            if (done_valid || step) dones++;
            @(negedge clk);
        end
        check("rst_no_done", dones, 0);
        v = (v + 2) % 256;
        check("rst_counter", data_out, to_bcd(v));
        run_cmd(2'd3, 0, 12'h000, 0);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) d = to_bcd($urandom_range(0, 255));
            else                          d = 12'($urandom_range(0, 4095));
            run_cmd(op, $urandom_range(0, 12), d, $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
